cpu_to_osci_intr_slave: RTL and testbench

CPU_TO_OSCI_INTR_SLAVE -- requirements
Module: cpu_to_osci_intr_slave

---
 rtl/cpu_to_osci_intr_slave.sv | 150 +++++++++++++++
 tb/tb_cpu_to_osci_intr_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_to_osci_intr_slave.sv
// AXI4-Lite interrupt controller: edge-latched STATUS, IER/GIE masking, write-1-to-clear ACK.
// Optional counter-driven self-test pulse on source 0 under CPU_TO_OSCI_INTR_SELFTEST_EN.
module cpu_to_osci_intr_slave #(
  parameter int unsigned C_NUM_OF_INTR      = 1,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s_axi_intr_aclk,
  input  logic                            s_axi_intr_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_intr_awaddr,
  input  logic [2:0]                      s_axi_intr_awprot,
  input  logic                            s_axi_intr_awvalid,
  output logic                            s_axi_intr_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_intr_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_intr_wstrb,
  input  logic                            s_axi_intr_wvalid,
  output logic                            s_axi_intr_wready,
  output logic [1:0]                      s_axi_intr_bresp,
  output logic                            s_axi_intr_bvalid,
  input  logic                            s_axi_intr_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_intr_araddr,
  input  logic [2:0]                      s_axi_intr_arprot,
  input  logic                            s_axi_intr_arvalid,
  output logic                            s_axi_intr_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_intr_rdata,
  output logic [1:0]                      s_axi_intr_rresp,
  output logic                            s_axi_intr_rvalid,
  input  logic                            s_axi_intr_rready,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  output logic                            irq
);
  localparam int unsigned NI = C_NUM_OF_INTR;
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned IW = AW - 2;

  localparam logic [IW-1:0] A_GIE    = IW'(0);
  localparam logic [IW-1:0] A_IER    = IW'(1);
  localparam logic [IW-1:0] A_STATUS = IW'(2);
  localparam logic [IW-1:0] A_ACK    = IW'(3);
  localparam logic [IW-1:0] A_PEND   = IW'(4);

  logic          gie;
  logic [NI-1:0] ier;
  logic [NI-1:0] status;
  logic [NI-1:0] src_q;
  logic [NI-1:0] src_eff;
  logic [NI-1:0] ack_clr;
  logic [DW-1:0] wmask;
  logic [DW-1:0] wval;
  logic [DW-1:0] rd_word;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          wr_fire;
  logic          rd_fire;
  logic          unused_ok;

  assign s_axi_intr_bresp = 2'b00;
  assign s_axi_intr_rresp = 2'b00;

  assign wr_idx  = s_axi_intr_awaddr[AW-1:2];
  assign rd_idx  = s_axi_intr_araddr[AW-1:2];
  assign wr_fire = s_axi_intr_awready & s_axi_intr_wready & s_axi_intr_awvalid & s_axi_intr_wvalid;
  assign rd_fire = s_axi_intr_arready & s_axi_intr_arvalid;

  // Byte-lane strobes expanded to a bit mask
  always_comb begin
    wmask = '0;
    for (int b = 0; b < int'(DW / 8); b++) begin
      wmask[b*8 +: 8] = {8{s_axi_intr_wstrb[b]}};
    end
  end

  assign wval    = s_axi_intr_wdata & wmask;
  assign ack_clr = (wr_fire && (wr_idx == A_ACK)) ? wval[NI-1:0] : '0;

`ifdef CPU_TO_OSCI_INTR_SELFTEST_EN
  logic [7:0] st_cnt;
  logic       st_pulse;

  // Free-running self-test counter; pulses source 0 on each 255->0 wrap
  always_ff @(posedge s_axi_intr_aclk) begin
    if (s_axi_intr_areset) begin
      st_cnt   <= 8'd0;
      st_pulse <= 1'b0;
    end else begin
      st_pulse <= gie && (st_cnt == 8'hFF);
      if (gie) st_cnt <= st_cnt + 8'd1;
    end
  end

  assign src_eff = intr_src | NI'(st_pulse);
`else
  assign src_eff = intr_src;
`endif

  // Read mux; STATUS/PENDING sampled before any same-cycle write lands
  always_comb begin
    rd_word = '0;
    case (rd_idx)
      A_GIE:    rd_word = DW'(gie);
      A_IER:    rd_word = DW'(ier);
      A_STATUS: rd_word = DW'(status);
      A_PEND:   rd_word = DW'(status & ier);
      default:  rd_word = '0;
    endcase
  end

  always_ff @(posedge s_axi_intr_aclk) begin
    if (s_axi_intr_areset) begin
      s_axi_intr_awready <= 1'b0;
      s_axi_intr_wready  <= 1'b0;
      s_axi_intr_bvalid  <= 1'b0;
      s_axi_intr_arready <= 1'b0;
      s_axi_intr_rvalid  <= 1'b0;
      s_axi_intr_rdata   <= '0;
      gie                <= 1'b0;
      ier                <= '0;
      status             <= '0;
      src_q              <= '0;
      irq                <= 1'b0;
    end else begin
      // Accept a write only when no response is outstanding
      s_axi_intr_awready <= s_axi_intr_awvalid & s_axi_intr_wvalid & ~s_axi_intr_bvalid & ~s_axi_intr_awready;
      s_axi_intr_wready  <= s_axi_intr_awvalid & s_axi_intr_wvalid & ~s_axi_intr_bvalid & ~s_axi_intr_awready;
      if (wr_fire)                s_axi_intr_bvalid <= 1'b1;
      else if (s_axi_intr_bready) s_axi_intr_bvalid <= 1'b0;

      s_axi_intr_arready <= s_axi_intr_arvalid & ~s_axi_intr_rvalid & ~s_axi_intr_arready;
      if (rd_fire) begin
        s_axi_intr_rvalid <= 1'b1;
        s_axi_intr_rdata  <= rd_word;
      end else if (s_axi_intr_rready) begin
        s_axi_intr_rvalid <= 1'b0;
      end

      if (wr_fire && (wr_idx == A_GIE) && s_axi_intr_wstrb[0]) gie <= s_axi_intr_wdata[0];
      if (wr_fire && (wr_idx == A_IER)) ier <= (ier & ~wmask[NI-1:0]) | wval[NI-1:0];

      // New rising edges override a same-cycle ACK clear
      src_q  <= src_eff;
      status <= (status & ~ack_clr) | (src_eff & ~src_q);
      irq    <= gie & (|(status & ier));
    end
  end

  assign unused_ok = ^{s_axi_intr_awprot, s_axi_intr_arprot, s_axi_intr_awaddr[1:0],
                       s_axi_intr_araddr[1:0], wval, wmask};

endmodule

// File: tb/tb_cpu_to_osci_intr_slave.sv
// Randomized self-checking bench for cpu_to_osci_intr_slave against a register-level model.
module tb_cpu_to_osci_intr_slave;
  localparam int unsigned NI = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [NI-1:0] intr_src;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  logic          m_gie;
  logic [NI-1:0] m_ier, m_status, m_src;

  cpu_to_osci_intr_slave #(.C_NUM_OF_INTR(NI), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .s_axi_intr_aclk(clk), .s_axi_intr_areset(rst),
    .s_axi_intr_awaddr(awaddr), .s_axi_intr_awprot(awprot), .s_axi_intr_awvalid(awvalid),
    .s_axi_intr_awready(awready), .s_axi_intr_wdata(wdata), .s_axi_intr_wstrb(wstrb),
    .s_axi_intr_wvalid(wvalid), .s_axi_intr_wready(wready), .s_axi_intr_bresp(bresp),
    .s_axi_intr_bvalid(bvalid), .s_axi_intr_bready(bready), .s_axi_intr_araddr(araddr),
    .s_axi_intr_arprot(arprot), .s_axi_intr_arvalid(arvalid), .s_axi_intr_arready(arready),
    .s_axi_intr_rdata(rdata), .s_axi_intr_rresp(rresp), .s_axi_intr_rvalid(rvalid),
    .s_axi_intr_rready(rready), .intr_src(intr_src), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    case (a[4:2])
      3'd0:    return 32'(m_gie);
      3'd1:    return 32'(m_ier);
      3'd2:    return 32'(m_status);
      3'd4:    return 32'(m_status & m_ier);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    case (a[4:2])
      3'd0:    if (s[0]) m_gie = d[0];
      3'd1:    m_ier = NI'((32'(m_ier) & ~m) | (d & m));
      3'd3:    m_status = m_status & ~NI'(d & m);
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_gie = 1'b0; m_ier = '0; m_status = '0; m_src = '0;
  endtask

  task automatic check_irq(input string tag);
    check(tag, 32'(irq), 32'(m_gie & (|(m_status & m_ier))));
  endtask

  // Full write transaction; optionally changes intr_src so its edge lands with the write
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit chg, input logic [NI-1:0] nsrc);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!awready && n < 20) begin tick(1); n++; end
    check("aw_ready", 32'(awready & wready), 32'd1);
    if (chg) intr_src = nsrc;
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(1); n++; end
    check("bvalid", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'd0);
    tick(1);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 20) begin tick(1); n++; end
    tick(1);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(1); n++; end
    check("rvalid", 32'(rvalid), 32'd1);
    check("rresp", 32'(rresp), 32'd0);
    d = rdata;
    tick(1);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    axi_write(a, d, s, 1'b0, '0);
    model_write(a, d, s);
    check_irq("irq_after_wr");
  endtask

  task automatic do_read(input string tag, input logic [4:0] a);
    logic [31:0] d;
    axi_read(a, d);
    check(tag, d, exp_read(a));
  endtask

  task automatic set_src(input logic [NI-1:0] nsrc);
    intr_src = nsrc;
    m_status = m_status | (nsrc & ~m_src);
    m_src = nsrc;
    tick(2);
    check_irq("irq_after_src");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    intr_src = '0;
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] held;
    int n;
    rst = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0; intr_src = '0;
    model_reset();
    tick(1);
    do_reset();

    check("rst_irq", 32'(irq), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    for (int i = 0; i < 5; i++) do_read("rst_reg", 5'(i * 4));

`ifdef CPU_TO_OSCI_INTR_SELFTEST_EN
    do_write(5'h04, 32'h1, 4'hF);
    do_write(5'h00, 32'h1, 4'hF);
    n = 0;
    while (!irq && n < 258) begin tick(1); n++; end
    check("st_irq", 32'(irq), 32'd1);
    axi_write(5'h0C, 32'h1, 4'hF, 1'b0, '0);
    axi_read(5'h10, d);
    check("st_pend", d, 32'd0);
`else
    // Enabled source: irq one cycle after STATUS latches
    do_write(5'h00, 32'h1, 4'hF);
    do_write(5'h04, 32'h1, 4'hF);
    intr_src = NI'(1);
    m_status = m_status | NI'(1); m_src = NI'(1);
    tick(1);
    check("irq_lat0", 32'(irq), 32'd0);
    tick(1);
    check("irq_lat1", 32'(irq), 32'd1);
    do_read("status_set", 5'h08);
    do_read("pend_set", 5'h10);
    do_write(5'h0C, 32'h1, 4'hF);
    do_read("pend_ack", 5'h10);
    do_read("status_held_src", 5'h08);
    set_src('0);

    // Masked source latches STATUS but not irq
    do_write(5'h04, 32'h0, 4'hF);
    set_src(NI'(1));
    do_read("status_masked", 5'h08);
    do_read("pend_masked", 5'h10);
    do_write(5'h04, 32'h1, 4'hF);
    check("irq_unmask", 32'(irq), 32'd1);
    do_write(5'h0C, 32'h1, 4'hF);
    set_src('0);

    // Rise coincident with ACK: set wins
    axi_write(5'h0C, 32'h1, 4'hF, 1'b1, NI'(1));
    model_write(5'h0C, 32'h1, 4'hF);
    m_status = m_status | NI'(1); m_src = NI'(1);
    do_read("set_wins", 5'h08);
    set_src('0);

    // Strobe honoured on IER upper lane only
    do_write(5'h04, 32'h0000_0F0F, 4'h2);
    do_read("ier_strb", 5'h04);

    // Stalled B channel blocks a queued write
    awaddr = 5'h04; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin tick(1); n++; end
    tick(1);
    model_write(5'h04, 32'h3, 4'hF);
    wdata = 32'h5;
    for (int i = 0; i < 10; i++) begin
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("aw_blocked", 32'(awready), 32'd0);
      tick(1);
    end
    bready = 1'b1;
    tick(1);
    check("bvalid_drop", 32'(bvalid), 32'd0);
    n = 0;
    while (!awready && n < 20) begin tick(1); n++; end
    check("aw_second", 32'(awready), 32'd1);
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(5'h04, 32'h5, 4'hF);
    tick(1);
    do_read("ier_second", 5'h04);
    do_read("unmapped", 5'h14);

    // Stalled R channel holds data
    araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin tick(1); n++; end
    tick(1);
    arvalid = 1'b0;
    held = rdata;
    for (int i = 0; i < 5; i++) begin
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, exp_read(5'h04));
      tick(1);
    end
    rready = 1'b1;
    tick(1);
    check("rvalid_drop", 32'(rvalid), 32'd0);
    check("rdata_stable", rdata, held);

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      int unsigned op;
      logic [4:0] a;
      op = $urandom_range(0, 2);
      a = {3'($urandom_range(0, 7)), 2'b00};
      case (op)
        0: do_write(a, $urandom, 4'($urandom));
        1: do_read("rand_rd", a);
        default: set_src(NI'($urandom));
      endcase
    end

    // Reset during outstanding B and R responses
    awaddr = 5'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!(bvalid && rvalid) && n < 20) begin tick(1); n++; end
    check("pre_abort", 32'(bvalid & rvalid), 32'd1);
    do_reset();
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abort_b", 32'(bvalid), 32'd0);
      check("abort_r", 32'(rvalid), 32'd0);
      tick(1);
    end
    do_read("post_rst_gie", 5'h00);
    do_read("post_rst_ier", 5'h04);
    check_irq("post_rst_irq");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
